// File: rtl/led_disp_pkg.sv
// led_disp_pkg: arbiter state type, scan constants and hex-to-segment encoder for led_display_arbiter (no ports)
package led_disp_pkg;
    typedef enum logic {IDLE, HOLD} arb_state_t;
    localparam int PHASE_W = 3;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_0 = 8'hFC;
    localparam logic [7:0] SEG_1 = 8'h60;
    localparam logic [7:0] SEG_2 = 8'hDA;
    localparam logic [7:0] SEG_3 = 8'hF2;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'hB6;
    localparam logic [7:0] SEG_6 = 8'hBE;
    localparam logic [7:0] SEG_7 = 8'hE0;
    localparam logic [7:0] SEG_8 = 8'hFE;
    localparam logic [7:0] SEG_9 = 8'hF6;
    localparam logic [7:0] SEG_A = 8'hEE;
    localparam logic [7:0] SEG_B = 8'h3E;
    localparam logic [7:0] SEG_C = 8'h9C;
    localparam logic [7:0] SEG_D = 8'h7A;
    localparam logic [7:0] SEG_E = 8'h9E;
    localparam logic [7:0] SEG_F = 8'h8E;
    localparam logic [7:0] SEG_HEX [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                           SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
    localparam logic [3:0] SEL_DEAD = 4'b0000;
    localparam logic [3:0] SEL_DIGIT [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    function automatic logic [7:0] seg_encode(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction
endpackage

// File: rtl/led_display_arbiter_if.sv
// led_display_arbiter_if: requester bus and display pins; master = requesters/board side, slave = arbiter
interface led_display_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] value;
    logic [NUM_REQ-1:0]    grant;
    logic [15:0]           shown_value;
    logic [7:0]            digitcode;
    logic [3:0]            selectors;
    modport master (output req, value, input grant, shown_value, digitcode, selectors);
    modport slave (input req, value, output grant, shown_value, digitcode, selectors);
endinterface

// File: rtl/led_rr_arbiter.sv
// led_rr_arbiter: round-robin grant with minimum dwell; ports clock, reset, req in, grant/owner/next_owner/load out
module led_rr_arbiter
    import led_disp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWELL = 1024,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   owner,
    output logic [IDX_W-1:0]   next_owner,
    output logic               load
);
    localparam int DW_W = $clog2(DWELL + 1);
    arb_state_t state, state_n;
    logic [DW_W-1:0] dwell;
    logic found;
    // owner doubles as the last-owner pointer while idle; the search wraps all the way
    // round so a lone requesting owner finds itself and keeps the grant
    always_comb begin
        next_owner = owner;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req[(int'(owner) + i) % NUM_REQ]) begin
                next_owner = IDX_W'((int'(owner) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
    // load marks every grant change, including the drop back to idle
    always_comb begin
        state_n = |req ? HOLD : IDLE;
        load = (state == IDLE) ? |req : (!req[owner] || (dwell == DW_W'(DWELL) && next_owner != owner));
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            owner <= IDX_W'(NUM_REQ - 1);
            dwell <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                grant <= |req ? NUM_REQ'(1) << next_owner : '0;
                owner <= next_owner;
                dwell <= '0;
            end else if (state == HOLD && dwell != DW_W'(DWELL)) begin
                dwell <= dwell + 1'b1;
            end
        end
    end
endmodule

// File: rtl/led_display_arbiter.sv
// led_display_arbiter: shares a 4-digit 7-seg display between requesters with dead-time digit scan
// Ports: clock, reset (async, active-high), bus (slave: req/value in; grant/shown_value/digitcode/selectors out)
// Build option LED_DISP_ACTIVE_LOW_EN inverts digitcode and selectors for common-anode boards.
module led_display_arbiter
    import led_disp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWELL = 1024,
    parameter int SCAN_DIV = 4
) (
    input logic clock,
    input logic reset,
    led_display_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PRE_W = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
`ifdef LED_DISP_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    logic [IDX_W-1:0]   owner, next_owner;
    logic               load, tick, active;
    logic [PRE_W-1:0]   pre;
    logic [PHASE_W-1:0] phase;
    logic [15:0]        shown;
    logic [3:0]         nibble, sel_n;
    logic [7:0]         code_n;
    led_rr_arbiter #(.NUM_REQ(NUM_REQ), .DWELL(DWELL)) u_arb (
        .clock(clock), .reset(reset), .req(bus.req), .grant(bus.grant),
        .owner(owner), .next_owner(next_owner), .load(load)
    );
    // even phase 2k is dead time for digit k, odd phase 2k+1 lights it; digit 0 is the top nibble
    always_comb begin
        tick = pre == PRE_W'(SCAN_DIV - 1);
        active = |bus.grant;
        nibble = 4'(shown >> {~phase[2:1], 2'b00});
        code_n = active ? seg_encode(nibble) : SEG_BLANK;
        sel_n = (active && phase[0]) ? SEL_DIGIT[phase[2:1]] : SEL_DEAD;
    end
    assign bus.shown_value = shown;
    // value is latched only at frame boundaries so a frame never mixes two values
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre <= '0;
            phase <= '0;
            shown <= '0;
        end else if (load) begin
            pre <= '0;
            phase <= '0;
            shown <= bus.value[{next_owner, 4'b0000} +: 16];
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) phase <= phase + 1'b1;
            if (tick && &phase && active) shown <= bus.value[{owner, 4'b0000} +: 16];
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.digitcode <= {8{INV}};
            bus.selectors <= {4{INV}};
        end else begin
            bus.digitcode <= code_n ^ {8{INV}};
            bus.selectors <= sel_n ^ {4{INV}};
        end
    end
endmodule

// File: doc/led_display_arbiter.md
Name: led_display_arbiter

Overview:
- Shares the 4-digit 7-segment display between up to NUM_REQ requesters, e.g. dip-switch echo, PC and debug register.
- Round-robin arbiter with a minimum dwell time chooses which 16-bit hex value is shown.
- The block then scans the digits with explicit dead-time phases to avoid ghosting.
- Sits between the datapath debug taps and the board segment/anode pins, replacing direct single-source display drive.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DWELL, 1024, minimum cycles a grant is held before rotating to another pending requester (>=1)
- SCAN_DIV, 4, clock cycles per scan phase (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester display request, level
- value  in  16*NUM_REQ  requester i value at bits [16*i+15:16*i]
- grant  out  NUM_REQ  one-hot (or zero) current owner, registered
- shown_value  out  16  value currently being displayed, registered
- digitcode  out  8  segments a..g,dp, MSB = a; active-high unless feature enabled
- selectors  out  4  digit enables, MSB = leftmost digit

Behaviour:
- Reset (async): grant=0, shown_value=0, digitcode=0, selectors=0, phase=0, prescaler=0, dwell counter=0, last-owner pointer=NUM_REQ-1.
- Arbiter states: IDLE (grant==0) and HOLD.
- IDLE, any req: next cycle grant = first requesting index searched from last+1 upward (mod NUM_REQ). Go to HOLD, dwell=0.
- HOLD, dwell counter: increments each cycle and saturates at DWELL.
- HOLD, owner drops req: grant changes the next cycle regardless of dwell. New owner comes from round-robin among the others, or the block goes to IDLE (grant=0) if none request.
- HOLD, dwell==DWELL and another index requesting: rotate to the next requesting index after the owner. The owner keeps the grant while it is the only requester.
- Simultaneous drop by the owner and new requests: same as owner drop, with round-robin from the owner index.
- On every grant change, in the same cycle:
  - shown_value loads the new owner's value;
  - phase and prescaler reset to 0;
  - dwell resets to 0.
- Otherwise shown_value reloads from the owner's value only when phase wraps 7->0. This gives a tear-free frame.
- Scan timing:
  - prescaler counts 0..SCAN_DIV-1; phase (0..7) advances when prescaler==SCAN_DIV-1;
  - phase 7 wraps to 0.
- Outputs are registered, one cycle behind phase/shown_value.
- Even phase 2k (dead time): selectors=0000, digitcode = encode(nibble k), where nibble 0 = shown_value[15:12] ... nibble 3 = [3:0].
- Odd phase 2k+1: digitcode held, selectors one-hot (k=0 ->1000, 1 ->0100, 2 ->0010, 3 ->0001).
- grant==0: digitcode=0 and selectors=0 in all phases.
- encode: standard hex table; 0 = 11111100, 1 = 01100000, ..., 9 = 11110110, A = 11101110, F = 10001110; dp always 0.
- Latency: req rises at edge t from IDLE -> grant/shown_value at t+1 -> first digitcode at t+2 -> first selector at t+2+SCAN_DIV.

Optional Feature:
- LED_DISP_ACTIVE_LOW_EN defined: digitcode and selectors are bitwise inverted at the output register for common-anode boards. Reset value is then all-ones; dead time is selectors=1111.
- Undefined: active-high as described above.

Decomposition:
- Package led_disp_pkg:
  - SEG_* hex encode constants and the encode function;
  - phase width (3) and digit-select one-hot constants;
  - localparam for blank code.
- One sub-module, led_rr_arbiter, is natural: round-robin pointer, dwell counter, grant register. The top-level holds the scan sequencer and encoder.

Test Plan:
- Reset mid-scan with req[0]=1: all outputs 0 asynchronously. After release, grant=0001 one cycle later.
- req=0001, value0=16'h1A3F, SCAN_DIV=2: digitcode sequence 01100000, 11101110, 11110010, 10001110. Selectors 1000/0100/0010/0001 only in odd phases, 0000 in even phases.
- req=0011 from IDLE, DWELL=16: grant 0001 for exactly 17 cycles, then 0010, then 0001 again after a further 17.
- Owner req[1] drops at dwell=3 while req[2]=1: grant 0100 next cycle. shown_value = value2, phase=0.
- Owner changes value0 mid-frame from 16'h1234 to 16'h5678: digits 1,2,3,4 finish; next frame shows 5,6,7,8.
- Build with LED_DISP_ACTIVE_LOW_EN, value0=16'h0000: digitcode=00000011, selectors idle 1111, active 0111/1011/1101/1110.
